// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO (fifo_param, fifo_mem).
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 10;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Accepted-operation encoding: {push_ok, pop_ok}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy and thresholds need one extra bit to represent DEPTH itself
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with thresholds, occupancy count and registered read.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   alto,
  input  logic [ADDR_WIDTH:0]   bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg, count_next;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  push_ok, pop_ok;
  fifo_op_e              op;

  // A push into a full FIFO is still accepted when a pop frees a slot the same cycle
  assign pop_ok  = pop && (count_reg != '0);
  assign push_ok = push && ((count_reg != CW'(DEPTH)) || pop_ok);
  assign op      = fifo_op_e'({push_ok, pop_ok});

  always_comb begin
    count_next = count_reg;
    case (op)
      OP_PUSH: count_next = count_reg + CW'(1);
      OP_POP:  count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_reg),
    .wdata (data_in),
    .raddr (rd_ptr_reg),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      valid_reg <= pop_ok;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + ADDR_WIDTH'(1);
        data_out_reg <= mem_rdata;
      end
    end
  end

  assign data_out     = data_out_reg;
  assign valid_out    = valid_reg;
  assign count        = count_reg;
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= alto);
  assign almost_empty = (count_reg <= bajo);

`ifdef FIFO_ERR_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (push && !push_ok) overflow_reg  <= 1'b1;
      if (pop && !pop_ok)   underflow_reg <= 1'b1;
    end
  end

  assign overflow_err  = overflow_reg;
  assign underflow_err = underflow_reg;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fifo_param;

  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] alto = 4'd7;
  logic [CW-1:0] bajo = 4'd0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow_err, underflow_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents as a queue plus observed output state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_valid, m_ovf, m_udf;

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .alto(alto), .bajo(bajo), .data_out(data_out), .valid_out(valid_out),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock of traffic; outputs are settled 1 time unit after the edge on return
  task automatic cyc(input bit p, input bit r, input logic [DW-1:0] d);
    bit pop_ok, push_ok;
    push = p; pop = r; data_in = d;
    @(posedge clk);
    pop_ok  = r && (q.size() > 0);
    push_ok = p && ((q.size() < DEPTH) || pop_ok);
    m_valid = pop_ok;
    if (pop_ok) m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    if (p && !push_ok) m_ovf = 1'b1;
    if (r && !pop_ok) m_udf = 1'b1;
    #1;
    push = 1'b0; pop = 1'b0;
    $display("txn push=%0b pop=%0b din=%h -> count=%0d valid=%0b dout=%h",
             p, r, d, count, valid_out, data_out);
  endtask

  task automatic test_reset();
    reset = 1'b0; alto = 4'd7; bajo = 4'd0;
    model_reset();
    #12;
    @(posedge clk); #1 reset = 1'b1;
    #2;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
    n_cmp++; if (almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_cmp++; if (data_out !== 10'h000) begin n_bad++; $display("FAIL reset_data: got %h want 000", data_out); end
    n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", {overflow_err, underflow_err}); end
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, DW'(10'h090 + i));
      n_cmp++; if (count !== CW'(i + 1)) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 7)) begin n_bad++; $display("FAIL fill_almost_full: count %0d got %b want %b", i + 1, almost_full, (i + 1 >= 7)); end
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", full); end
    cyc(1'b1, 1'b0, 10'h3FF);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL overflow_count: got %0d want 8", count); end
    n_cmp++; if (overflow_err !== ERR_EN) begin n_bad++; $display("FAIL overflow_err: got %b want %b", overflow_err, ERR_EN); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      n_cmp++; if (valid_out !== 1'b1 || data_out !== DW'(10'h090 + i)) begin
        n_bad++; $display("FAIL drain_word %0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, DW'(10'h090 + i));
      end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", empty); end
    cyc(1'b0, 1'b1, '0);
    n_cmp++; if (valid_out !== 1'b0 || data_out !== 10'h097) begin
      n_bad++; $display("FAIL underflow_hold: got v=%b d=%h want v=0 d=097", valid_out, data_out);
    end
    n_cmp++; if (underflow_err !== ERR_EN) begin n_bad++; $display("FAIL underflow_err: got %b want %b", underflow_err, ERR_EN); end
  endtask

  task automatic test_back_to_back_full();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b1, DW'($urandom));
      n_cmp++; if (count !== 4'd8 || full !== 1'b1) begin n_bad++; $display("FAIL stream_count: got %0d want 8", count); end
      n_cmp++; if (valid_out !== 1'b1 || data_out !== m_dout) begin
        n_bad++; $display("FAIL stream_data %0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, m_dout);
      end
    end
    while (q.size() > 0) cyc(1'b0, 1'b1, '0);
  endtask

  task automatic test_push_pop_empty();
    cyc(1'b1, 1'b1, 10'h2A5);
    n_cmp++; if (count !== 4'd1 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL pp_empty: got count=%0d v=%b want count=1 v=0", count, valid_out);
    end
    n_cmp++; if (underflow_err !== ERR_EN) begin n_bad++; $display("FAIL pp_empty_udf: got %b want %b", underflow_err, ERR_EN); end
    cyc(1'b0, 1'b1, '0);
    n_cmp++; if (valid_out !== 1'b1 || data_out !== 10'h2A5) begin
      n_bad++; $display("FAIL pp_empty_pop: got v=%b d=%h want v=1 d=2a5", valid_out, data_out);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'(10'h150 + i));
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL midreset_async: got count=%0d empty=%b want 0/1", count, empty);
    end
    n_cmp++; if ({overflow_err, underflow_err} !== 2'b00) begin n_bad++; $display("FAIL midreset_err: got %b want 00", {overflow_err, underflow_err}); end
    @(posedge clk); #1 reset = 1'b1;
    cyc(1'b0, 1'b1, '0);
    n_cmp++; if (valid_out !== 1'b0 || count !== 4'd0) begin
      n_bad++; $display("FAIL midreset_pop: got v=%b count=%0d want v=0 count=0", valid_out, count);
    end
  endtask

  task automatic test_random();
    int bias;
    bit p, r;
    for (int i = 0; i < 400; i++) begin
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      if ($urandom_range(0, 9) == 0) begin
        alto = CW'($urandom_range(0, 15));
        bajo = CW'($urandom_range(0, 15));
      end
      p = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < (100 - bias));
      cyc(p, r, DW'($urandom));
      n_cmp++; if (count !== CW'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
        n_bad++; $display("FAIL rand_count %0d: got count=%0d f=%b e=%b want %0d", i, count, full, empty, q.size());
      end
      n_cmp++; if (almost_full !== (int'(q.size()) >= int'(alto)) || almost_empty !== (int'(q.size()) <= int'(bajo))) begin
        n_bad++; $display("FAIL rand_thresh %0d: got af=%b ae=%b count=%0d alto=%0d bajo=%0d", i, almost_full, almost_empty, q.size(), alto, bajo);
      end
      n_cmp++; if (valid_out !== m_valid || data_out !== m_dout) begin
        n_bad++; $display("FAIL rand_data %0d: got v=%b d=%h want v=%b d=%h", i, valid_out, data_out, m_valid, m_dout);
      end
      n_cmp++; if (overflow_err !== (m_ovf & ERR_EN) || underflow_err !== (m_udf & ERR_EN)) begin
        n_bad++; $display("FAIL rand_err %0d: got o=%b u=%b want o=%b u=%b", i, overflow_err, underflow_err, m_ovf & ERR_EN, m_udf & ERR_EN);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back_full();
    test_push_pop_empty();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
